// File: rtl/up_dn_counter_param.sv
// Parametrised up/down counter with programmable step, limits and saturate/wrap behaviour.
// Overflow/underflow are judged at WIDTH+1 bits so large steps never alias around zero.
module up_dn_counter_param #(
    parameter int unsigned      WIDTH     = 5,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             up,
    input  logic             down,
    input  logic [WIDTH-1:0] step,
    input  logic             wrap_mode,
    input  logic [WIDTH-1:0] lim_lo,
    input  logic [WIDTH-1:0] lim_hi,
    output logic [WIDTH-1:0] counter,
    output logic             high,
    output logic             low,
    output logic             ovf,
    output logic             unf,
    output logic             cfg_err
);

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH:0]   lo_ext;
    logic [WIDTH:0]   hi_ext;
    logic             over;
    logic             under;
    logic [WIDTH-1:0] clamped;
    logic [WIDTH-1:0] counter_next;
    logic             ovf_next;
    logic             unf_next;

    assign cfg_err = (lim_lo > lim_hi);
    assign high    = (counter >= lim_hi);
    assign low     = (counter <= lim_lo);

    assign lo_ext   = {1'b0, lim_lo};
    assign hi_ext   = {1'b0, lim_hi};
    assign sum_ext  = {1'b0, counter} + {1'b0, step};
    assign diff_ext = {1'b0, counter} - {1'b0, step};
    assign over     = (sum_ext > hi_ext);
    // counter < step covers the borrow case, where diff_ext has wrapped
    assign under    = (counter < step) || (diff_ext < lo_ext);

    always_comb begin
        clamped = in;
        if (in < lim_lo) begin
            clamped = lim_lo;
        end else if (in > lim_hi) begin
            clamped = lim_hi;
        end
    end

    always_comb begin
        counter_next = counter;
        ovf_next     = 1'b0;
        unf_next     = 1'b0;
        if (load) begin
            counter_next = cfg_err ? in : clamped;
        end else if (!cfg_err && (step != '0)) begin
            if (down) begin
                if (under) begin
                    unf_next     = 1'b1;
                    counter_next = wrap_mode ? lim_hi : lim_lo;
                end else begin
                    counter_next = diff_ext[WIDTH-1:0];
                end
            end else if (up) begin
                if (over) begin
                    ovf_next     = 1'b1;
                    counter_next = wrap_mode ? lim_lo : lim_hi;
                end else begin
                    counter_next = sum_ext[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter <= RESET_VAL;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else begin
            counter <= counter_next;
            ovf     <= ovf_next;
            unf     <= unf_next;
        end
    end

endmodule
